hdmi_text_axi_slave: RTL

HDMI_TEXT_AXI_SLAVE -- requirements
Module: hdmi_text_axi_slave

---
 rtl/hdmi_text_axi_slave.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_text_axi_slave.sv
// AXI4-Lite slave holding a 600-word text VRAM plus one control word, with a registered
// video-side read port. Define TEXT_AXI_SLVERR_EN to answer out-of-range accesses with SLVERR.
module hdmi_text_axi_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic [2:0]                      axi_awprot,
  input  logic                            axi_awvalid,
  output logic                            axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]     axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                            axi_wvalid,
  output logic                            axi_wready,
  output logic [1:0]                      axi_bresp,
  output logic                            axi_bvalid,
  input  logic                            axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_araddr,
  input  logic [2:0]                      axi_arprot,
  input  logic                            axi_arvalid,
  output logic                            axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]     axi_rdata,
  output logic [1:0]                      axi_rresp,
  output logic                            axi_rvalid,
  input  logic                            axi_rready,
  input  logic [9:0]                      vid_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]     vid_data,
  output logic [C_AXI_DATA_WIDTH-1:0]     ctrl_reg
);
  localparam int                        NUM_REGS = 601;
  localparam int                        NB       = C_AXI_DATA_WIDTH / 8;
  localparam logic [9:0]                CTRL_IDX = 10'd600;
  localparam logic [C_AXI_DATA_WIDTH-1:0] ZERO_W = {C_AXI_DATA_WIDTH{1'b0}};
  localparam logic [1:0]                RESP_OKAY = 2'b00;
`ifdef TEXT_AXI_SLVERR_EN
  localparam logic [1:0]                RESP_OOR  = 2'b10;
`else
  localparam logic [1:0]                RESP_OOR  = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  // Addresses outside the 4 KiB window alias nothing: they are out of range like index > 600.
  function automatic logic addr_ok(input logic [C_AXI_ADDR_WIDTH-1:0] a);
    return (a[C_AXI_ADDR_WIDTH-1:12] == {(C_AXI_ADDR_WIDTH-12){1'b0}}) && (a[11:2] <= CTRL_IDX);
  endfunction

  logic [C_AXI_DATA_WIDTH-1:0]   mem_q [0:NUM_REGS-1];
  wstate_e                       wstate_q, wstate_d;
  rstate_e                       rstate_q, rstate_d;
  logic [C_AXI_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]                 wstrb_q, wstrb_d;
  logic [1:0]                    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [C_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d, vid_data_q;
  logic                          awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
  logic                          aw_hs_s, w_hs_s, ar_hs_s, cm_en_s;
  logic [C_AXI_ADDR_WIDTH-1:0]   cm_addr_s;
  logic [C_AXI_DATA_WIDTH-1:0]   cm_data_s;
  logic [NB-1:0]                 cm_strb_s;
  logic                          unused_s;

  assign aw_hs_s = axi_awvalid & awready_q;
  assign w_hs_s  = axi_wvalid & wready_q;
  assign ar_hs_s = axi_arvalid & arready_q;

  // Write channel: collects AW and W in either order, commits on the second handshake.
  always_comb begin
    wstate_d  = wstate_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    cm_en_s   = 1'b0;
    cm_addr_s = waddr_q;
    cm_data_s = wdata_q;
    cm_strb_s = wstrb_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          cm_en_s   = 1'b1;
          cm_addr_s = axi_awaddr;
          cm_data_s = axi_wdata;
          cm_strb_s = axi_wstrb;
          wstate_d  = W_RESP;
        end else if (aw_hs_s) begin
          waddr_d  = axi_awaddr;
          wstate_d = W_HAVE_ADDR;
        end else if (w_hs_s) begin
          wdata_d  = axi_wdata;
          wstrb_d  = axi_wstrb;
          wstate_d = W_HAVE_DATA;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs_s) begin
          cm_en_s   = 1'b1;
          cm_data_s = axi_wdata;
          cm_strb_s = axi_wstrb;
          wstate_d  = W_RESP;
        end else begin
          wstate_d = W_HAVE_ADDR;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs_s) begin
          cm_en_s   = 1'b1;
          cm_addr_s = axi_awaddr;
          wstate_d  = W_RESP;
        end else begin
          wstate_d = W_HAVE_DATA;
        end
      end
      W_RESP: begin
        if (axi_bready) wstate_d = W_IDLE;
        else            wstate_d = W_RESP;
      end
      default: wstate_d = W_IDLE;
    endcase
    if (cm_en_s) bresp_d = addr_ok(cm_addr_s) ? RESP_OKAY : RESP_OOR;
    else         bresp_d = bresp_q;
  end

  // Read channel: the register file is sampled on the AR handshake edge, so a same-edge write is not seen.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rstate_d = R_DATA;
          if (addr_ok(axi_araddr)) begin
            rdata_d = mem_q[axi_araddr[11:2]];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = ZERO_W;
            rresp_d = RESP_OOR;
          end
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (axi_rready) rstate_d = R_IDLE;
        else            rstate_d = R_DATA;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Handshake state; ready/valid flags are registered from next state so they stay low during reset.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      waddr_q   <= {C_AXI_ADDR_WIDTH{1'b0}};
      wdata_q   <= ZERO_W;
      wstrb_q   <= {NB{1'b0}};
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= ZERO_W;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      awready_q <= (wstate_d == W_IDLE) || (wstate_d == W_HAVE_DATA);
      wready_q  <= (wstate_d == W_IDLE) || (wstate_d == W_HAVE_ADDR);
      arready_q <= (rstate_d == R_IDLE);
      bvalid_q  <= (wstate_d == W_RESP);
      rvalid_q  <= (rstate_d == R_DATA);
    end
  end

  // Register file with per-byte-lane commit.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= ZERO_W;
    end else if (cm_en_s && addr_ok(cm_addr_s)) begin
      for (int b = 0; b < NB; b++) begin
        if (cm_strb_s[b]) mem_q[cm_addr_s[11:2]][8*b +: 8] <= cm_data_s[8*b +: 8];
      end
    end
  end

  // Video-side read port, one cycle of latency.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)             vid_data_q <= ZERO_W;
    else if (vid_addr <= CTRL_IDX) vid_data_q <= mem_q[vid_addr];
    else                          vid_data_q <= ZERO_W;
  end

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_arready = arready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rresp   = rresp_q;
  assign axi_rdata   = rdata_q;
  assign vid_data    = vid_data_q;
  assign ctrl_reg    = mem_q[CTRL_IDX];
  assign unused_s    = ^{axi_awprot, axi_arprot, axi_araddr[1:0], cm_addr_s[1:0]};

endmodule
